// File: rtl/uut_seq_pkg.sv
// Shared types and constants for the UUT run sequencer.
package uut_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    CAPTURE,
    SEND
  } state_t;

  // Record header: 4 cycle-count bytes followed by 1 status byte.
  localparam int unsigned RECORD_HDR_BYTES   = 5;
  localparam int unsigned STATUS_TIMEOUT_BIT = 0;

  // Width of the run cycle counter and of the count field in the record.
  localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/uut_record_serializer.sv
// Loads the run record in parallel and shifts it out MSB byte first over a
// valid/ready byte interface. last_o marks the transfer of the final byte.
module uut_record_serializer
  import uut_seq_pkg::*;
#(
  parameter int unsigned OUTPUT_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [CNT_W-1:0]       count_i,
  input  logic [7:0]             status_i,
  input  logic [OUTPUT_SIZE-1:0] result_i,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   last_o
);

  localparam int unsigned REC_BYTES = RECORD_HDR_BYTES + OUTPUT_SIZE / 8;
  localparam int unsigned REC_W     = REC_BYTES * 8;
  localparam int unsigned REM_W     = $clog2(REC_BYTES);

  logic [REC_W-1:0] sh_q, sh_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  logic             xfer;

  assign xfer       = valid_q & byte_ready;
  assign last_o     = xfer & (rem_q == '0);
  assign byte_valid = valid_q;
  // Shifting left with zero fill leaves the register cleared once the record
  // has gone, so byte_data reads 0 whenever no record is pending.
  assign byte_data  = sh_q[REC_W-1 -: 8];

  // Next shift-register contents, remaining-byte count and valid flag.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    sh_d    = sh_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    if (load_i) begin
      sh_d    = {count_i, status_i, result_i};
      rem_d   = REM_W'(REC_BYTES - 1);
      valid_d = 1'b1;
    end else if (xfer) begin
      sh_d = sh_q << 8;
      if (rem_q == '0) begin
        valid_d = 1'b0;
      end else begin
        rem_d = rem_q - REM_W'(1);
      end
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real flops do.
    if (!rst_n) begin
      // NOTE: the shift register is reset too, because its top byte drives
      // byte_data directly and that output must be 0 out of reset.
      sh_q    <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/uut_run_sequencer.sv
// Runs one UUT test per accepted start: latches operands, holds the UUT in
// reset, times the run until end_uut or a timeout, then streams the record.
module uut_run_sequencer
  import uut_seq_pkg::*;
#(
  parameter int unsigned INPUT_SIZE_1   = 32,
  parameter int unsigned INPUT_SIZE_2   = 32,
  parameter int unsigned OUTPUT_SIZE    = 32,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 32'h00FF_FFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [INPUT_SIZE_1-1:0] op1_i,
  input  logic [INPUT_SIZE_2-1:0] op2_i,
  input  logic [1:0]              clk_sel_i,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic                    rst_uut,
  input  logic                    end_uut,
  output logic [INPUT_SIZE_1-1:0] input_to_UUT_1,
  output logic [INPUT_SIZE_2-1:0] input_to_UUT_2,
  input  logic [OUTPUT_SIZE-1:0]  output_from_UUT,
  output logic [1:0]              clk_uut_sel,
  output logic [7:0]              byte_data,
  output logic                    byte_valid,
  input  logic                    byte_ready
);

  localparam logic [CNT_W-1:0] RST_LIM = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);
  // A stale end may persist for TIMEOUT_CYCLES cycles after the hold period.
  localparam logic [CNT_W:0]   STALE_LIM =
    (CNT_W+1)'(RST_CYCLES) + (CNT_W+1)'(TIMEOUT_CYCLES) - (CNT_W+1)'(1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [INPUT_SIZE_1-1:0] op1_q, op1_d;
  logic [INPUT_SIZE_2-1:0] op2_q, op2_d;
  logic [1:0]              sel_q, sel_d;
  logic                    timeout_q, timeout_d;
  logic                    done_q, done_d;
  logic                    rst_uut_q, rst_uut_d;
  logic                    end_meta_q, end_s_q;
  logic                    ser_load, ser_last;
  logic [7:0]              status_byte;

  // The counter sticks at all-ones rather than wrapping.
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign status_byte = 8'(timeout_q) << STATUS_TIMEOUT_BIT;

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign rst_uut        = rst_uut_q;
  assign input_to_UUT_1 = op1_q;
  assign input_to_UUT_2 = op2_q;
  assign clk_uut_sel    = sel_q;

  // Two-flop synchronizer for the UUT's asynchronous completion flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      end_meta_q <= 1'b0;
      end_s_q    <= 1'b0;
    end else begin
      end_meta_q <= end_uut;
      end_s_q    <= end_meta_q;
    end
  end

  // Run sequencing: next state, counter, latched operands and status.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    sel_d     = sel_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    ser_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op1_d     = op1_i;
          op2_d     = op2_i;
          sel_d     = clk_sel_i;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = RST;
        end
      end
      RST: begin
        if (cnt_q < RST_LIM) begin
          cnt_d = cnt_inc;
        end else if (!end_s_q) begin
          cnt_d   = '0;
          state_d = RUN;
        end else if ({1'b0, cnt_q} >= STALE_LIM) begin
          timeout_d = 1'b1;
          state_d   = CAPTURE;
        end else begin
          // Still holding off a stale end left over from the previous run.
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        // End is tested first, so it wins when both land on the same cycle.
        if (end_s_q) begin
          state_d = CAPTURE;
        end else if (cnt_q >= TO_LIM) begin
          timeout_d = 1'b1;
          state_d   = CAPTURE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      CAPTURE: begin
        ser_load = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (ser_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered from the next state so the UUT reset is glitch-free.
    rst_uut_d = (state_d != RUN);
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      sel_q     <= 2'b00;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      rst_uut_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      rst_uut_q <= rst_uut_d;
    end
  end

  uut_record_serializer #(
    .OUTPUT_SIZE(OUTPUT_SIZE)
  ) u_serializer (
    .clk       (clk),
    .rst_n     (rst),
    .load_i    (ser_load),
    .count_i   (cnt_q),
    .status_i  (status_byte),
    .result_i  (output_from_UUT),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .last_o    (ser_last)
  );

endmodule

// File: tb/tb_uut_run_sequencer.sv
// Self-checking bench for uut_run_sequencer: a run-level model predicts each
// record and the UUT reset timing; a negedge process compares every cycle.
module tb_uut_run_sequencer;

  localparam int RST_CYC   = 16;
  localparam int TO_CYC    = 1000;
  localparam int REC_BYTES = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op1_i = '0, op2_i = '0;
  logic [1:0]  clk_sel_i = '0;
  logic        busy, done, timeout, rst_uut;
  logic        end_uut = 1'b0;
  logic [31:0] input_to_UUT_1, input_to_UUT_2;
  logic [31:0] output_from_UUT = '0;
  logic [1:0]  clk_uut_sel;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready = 1'b1;

  always #5 clk = ~clk;

  uut_run_sequencer #(
    .INPUT_SIZE_1  (32),
    .INPUT_SIZE_2  (32),
    .OUTPUT_SIZE   (32),
    .RST_CYCLES    (RST_CYC),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .op1_i          (op1_i),
    .op2_i          (op2_i),
    .clk_sel_i      (clk_sel_i),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .rst_uut        (rst_uut),
    .end_uut        (end_uut),
    .input_to_UUT_1 (input_to_UUT_1),
    .input_to_UUT_2 (input_to_UUT_2),
    .output_from_UUT(output_from_UUT),
    .clk_uut_sel    (clk_uut_sel),
    .byte_data      (byte_data),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Run parameters for the UUT model and the record prediction.
  int          run_d      = 0;    // cycles from rst_uut fall to end_uut; <0 = never
  logic [31:0] run_result = '0;
  int          stale_left = 0;    // cycles end_uut lingers after rst_uut rises

  // Model state.
  int          cyc = 0;
  bit          m_busy = 0, m_done_exp = 0, m_timeout = 0, run_timeout = 0;
  logic [31:0] m_op1 = '0, m_op2 = '0;
  logic [1:0]  m_sel = '0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got[REC_BYTES];
  int          xfer_cnt = 0;
  int          s_cyc = 0, rel_cyc = -1000, exp_fall = 0;
  bit          prev_rst_uut = 1, prev_stall = 0;
  logic [7:0]  prev_data = '0;
  logic [31:0] exp_cnt;
  bit          exp_to;

  // Ready driver controls.
  bit stall_req = 0, rand_ready = 0;
  int stall_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // UUT model: raises end run_d cycles after its reset drops, clears it when
  // reset returns (optionally lingering stale_left cycles).
  int run_cyc = 0;
  always @(negedge clk) begin
    if (!rst_uut) begin
      if (run_d >= 0 && run_cyc == run_d) end_uut = 1'b1;
      run_cyc++;
    end else begin
      run_cyc = 0;
      if (end_uut) begin
        if (stale_left > 0) stale_left--;
        else begin
          end_uut = 1'b0;
          rel_cyc = cyc;
        end
      end
    end
  end

  // Consumer ready: optional 7-cycle stall on the second byte, else random or high.
  always @(posedge clk) begin
    #2;
    if (stall_req && xfer_cnt == 1 && byte_valid && stall_n < 7) begin
      byte_ready = 1'b0;
      stall_n++;
    end else if (rand_ready) byte_ready = 1'($urandom_range(0, 1));
    else byte_ready = 1'b1;
  end

  // Compare process: outputs after posedge c are checked at negedge c, then
  // the model advances to predict posedge c+1.
  always @(negedge clk) begin
    if (!rst) begin
      m_busy = 0; m_done_exp = 0; m_timeout = 0;
      m_op1 = '0; m_op2 = '0; m_sel = '0;
      exp_q.delete(); xfer_cnt = 0;
      prev_rst_uut = 1; prev_stall = 0;
    end else begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done_exp));
      check("input_to_UUT_1", 64'(input_to_UUT_1), 64'(m_op1));
      check("input_to_UUT_2", 64'(input_to_UUT_2), 64'(m_op2));
      check("clk_uut_sel", 64'(clk_uut_sel), 64'(m_sel));
      if (!m_busy) begin
        check("idle_rst_uut", 64'(rst_uut), 64'd1);
        check("idle_byte_valid", 64'(byte_valid), 64'd0);
        check("timeout", 64'(timeout), 64'(m_timeout));
      end
      if (prev_stall) begin
        check("stall_valid", 64'(byte_valid), 64'd1);
        check("stall_data", 64'(byte_data), 64'(prev_data));
      end
      if (m_busy && prev_rst_uut && !rst_uut) begin
        exp_fall = s_cyc + RST_CYC + 1;
        if (rel_cyc + 3 > exp_fall) exp_fall = rel_cyc + 3;
        check("rst_uut_fall_cycle", 64'(cyc), 64'(exp_fall));
      end
      prev_rst_uut = rst_uut;
      prev_stall   = byte_valid && !byte_ready;
      prev_data    = byte_data;

      m_done_exp = 0;
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) check("extra_byte", 64'd1, 64'd0);
        else check("record_byte", 64'(byte_data), 64'(exp_q.pop_front()));
        if (xfer_cnt < REC_BYTES) got[xfer_cnt] = byte_data;
        xfer_cnt++;
        if (xfer_cnt == REC_BYTES) begin
          m_busy = 0; m_done_exp = 1; m_timeout = run_timeout;
        end
      end
      if (!m_busy && start) begin
        m_busy = 1; m_op1 = op1_i; m_op2 = op2_i; m_sel = clk_sel_i;
        s_cyc = cyc + 1; xfer_cnt = 0;
        if (run_d < 0 || run_d + 2 > TO_CYC) begin
          exp_cnt = 32'(TO_CYC); exp_to = 1'b1;
        end else begin
          exp_cnt = 32'(run_d + 2); exp_to = 1'b0;
        end
        run_timeout = exp_to;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_cnt[31-8*i -: 8]);
        exp_q.push_back({7'b0, exp_to});
        for (int i = 0; i < 4; i++) exp_q.push_back(run_result[31-8*i -: 8]);
      end
    end
  end

  task automatic start_run(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                           input int d, input logic [31:0] res);
    @(posedge clk); #2;
    run_d = d; run_result = res; output_from_UUT = res;
    op1_i = a; op2_i = b; clk_sel_i = s; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    op1_i = $urandom; op2_i = $urandom; clk_sel_i = 2'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      if (!m_busy) begin ok = 1; break; end
    end
    if (!ok) begin
      check("run_completes_in_budget", 64'd0, 64'd1);
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk); #2 rst = 1'b1;
    end
  endtask

  task automatic do_run(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                        input int d, input logic [31:0] res);
    start_run(a, b, s, d, res);
    wait_idle();
  endtask

  task automatic check_record(input string tag, input logic [71:0] e);
    for (int i = 0; i < REC_BYTES; i++) check(tag, 64'(got[i]), 64'(e[71-8*i -: 8]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_byte_valid", 64'(byte_valid), 64'd0);
    check("rst_byte_data", 64'(byte_data), 64'd0);
    check("rst_rst_uut", 64'(rst_uut), 64'd1);
    check("rst_op1", 64'(input_to_UUT_1), 64'd0);
    check("rst_op2", 64'(input_to_UUT_2), 64'd0);
    check("rst_sel", 64'(clk_uut_sel), 64'd0);
    @(posedge clk); #2 rst = 1'b1;

    // Normal run: 100 + 2 synchronizer cycles = 0x66.
    do_run(32'hDEAD_BEEF, 32'h0123_4567, 2'b10, 100, 32'hCAFE_F00D);
    check_record("normal_record", 72'h00_00_00_66_00_CA_FE_F0_0D);
    check("normal_op1", 64'(input_to_UUT_1), 64'hDEAD_BEEF);
    check("normal_op2", 64'(input_to_UUT_2), 64'h0123_4567);
    check("normal_timeout", 64'(timeout), 64'd0);

    // Timeout: end never arrives.
    do_run(32'h1, 32'h2, 2'b01, -1, 32'h5555_AAAA);
    check_record("timeout_record", 72'h00_00_03_E8_01_55_55_AA_AA);
    check("timeout_flag", 64'(timeout), 64'd1);

    // Boundary: end lands exactly at the limit (end wins), then one cycle late.
    do_run(32'h3, 32'h4, 2'b11, TO_CYC - 2, 32'h0000_0001);
    check_record("end_at_limit", 72'h00_00_03_E8_00_00_00_00_01);
    check("end_at_limit_timeout", 64'(timeout), 64'd0);
    do_run(32'h5, 32'h6, 2'b00, TO_CYC - 1, 32'h0000_0002);
    check_record("end_past_limit", 72'h00_00_03_E8_01_00_00_00_02);

    // Backpressure: 7-cycle stall on byte 2, random ready afterwards.
    stall_req = 1; stall_n = 0; rand_ready = 1;
    do_run(32'hA5A5_0001, 32'h5A5A_0002, 2'b01, 37, 32'h8765_4321);
    stall_req = 0; rand_ready = 0;
    check("stall_cycles_seen", 64'(stall_n), 64'd7);
    check_record("backpressure_record", 72'h00_00_00_27_00_87_65_43_21);

    // Stale end: end lingers 50 cycles after rst_uut rises, into the next run.
    stale_left = 50;
    do_run(32'h10, 32'h20, 2'b10, 20, 32'h0BAD_F00D);
    do_run(32'h30, 32'h40, 2'b01, 30, 32'h600D_CAFE);
    check_record("stale_record", 72'h00_00_00_20_00_60_0D_CA_FE);

    // Start while busy is ignored.
    start_run(32'h1111_2222, 32'h3333_4444, 2'b11, 200, 32'h0);
    repeat (60) @(posedge clk);
    #2 op1_i = 32'hFFFF_0000; op2_i = 32'h0000_FFFF; clk_sel_i = 2'b00; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_start_op1", 64'(input_to_UUT_1), 64'h1111_2222);
    check("busy_start_sel", 64'(clk_uut_sel), 64'd3);
    wait_idle();

    // Asynchronous reset in the middle of SEND.
    rand_ready = 1;
    start_run(32'hBEEF_0000, 32'h0000_BEEF, 2'b10, 10, 32'hFEED_FACE);
    for (int i = 0; i < 2000 && xfer_cnt < 3; i++) begin
      @(negedge clk); #1;
    end
    check("reached_byte_3", 64'(xfer_cnt), 64'd3);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("midsend_rst_byte_valid", 64'(byte_valid), 64'd0);
    check("midsend_rst_rst_uut", 64'(rst_uut), 64'd1);
    check("midsend_rst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    rand_ready = 0;
    do_run(32'h0F0F_0F0F, 32'hF0F0_F0F0, 2'b01, 40, 32'h1234_5678);
    check_record("after_reset_record", 72'h00_00_00_2A_00_12_34_56_78);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      rand_ready = 1'($urandom_range(0, 1));
      do_run($urandom, $urandom, 2'($urandom), int'($urandom_range(0, 150)), $urandom);
    end
    rand_ready = 0;

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
